// File: rtl/hrm_control_fsm_if.sv
// Control-unit port bundle: instruction and status flags into the FSM, datapath strobes out.
// master = control FSM, slave = datapath side.
interface hrm_control_fsm_if #(
    parameter int IW = 8
);
    logic [IW-1:0] INSTR;
    logic          inEmpty;
    logic          outFull;
    logic          debug;
    logic          nxtInstr;

    logic          wIR;
    logic          wR;
    logic          srcA;
    logic          wM;
    logic          wAR;
    logic          wPC;
    logic          rIn;
    logic          wO;
    logic          ijump;
    logic          branch;
    logic          rst;
    logic          halt;
    logic [1:0]    muxR;
    logic [2:0]    aluCtl;

    modport master (
        input  INSTR, inEmpty, outFull, debug, nxtInstr,
        output wIR, wR, srcA, wM, wAR, wPC, rIn, wO, ijump, branch, rst, halt, muxR, aluCtl
    );

    modport slave (
        output INSTR, inEmpty, outFull, debug, nxtInstr,
        input  wIR, wR, srcA, wM, wAR, wPC, rIn, wO, ijump, branch, rst, halt, muxR, aluCtl
    );
endinterface

// File: rtl/hrm_control_fsm.sv
// Instruction-sequencing control FSM with Moore datapath strobes; SET opcode enabled by `HRM_CU_SET_EN.
// Latency: one state per cycle, memory-access states (FETCH_I/FETCH_O/READMEM/READMEM2) held MEM_LAT cycles.
// Backpressure: stalls in WAIT_INBOX/WAIT_OUTBOX on inEmpty/outFull and in WAIT_KEY while single-stepping.
module hrm_control_fsm #(
    parameter int IW      = 8,
    parameter int MEM_LAT = 1
) (
    input  logic               clk,
    input  logic               i_rst,
    hrm_control_fsm_if.master  bus
);

    typedef enum logic [4:0] {
        S_RESET       = 5'd0,
        S_FETCH_I     = 5'd1,
        S_WAIT_KEY    = 5'd2,
        S_LOAD_IR     = 5'd3,
        S_DECODE      = 5'd4,
        S_WAIT_INBOX  = 5'd5,
        S_WAIT_OUTBOX = 5'd6,
        S_INBOX       = 5'd7,
        S_OUTBOX      = 5'd8,
        S_INC_PC      = 5'd9,
        S_INCPC2      = 5'd10,
        S_FETCH_O     = 5'd11,
        S_JUMP        = 5'd12,
        S_JUMPZ       = 5'd13,
        S_JUMPN       = 5'd14,
        S_LOAD_AR     = 5'd15,
        S_LOAD_AR2    = 5'd16,
        S_READMEM     = 5'd17,
        S_READMEM2    = 5'd18,
        S_COPYFROM    = 5'd19,
        S_ADD         = 5'd20,
        S_SUB         = 5'd21,
        S_BUMPP       = 5'd22,
        S_BUMPM       = 5'd23,
        S_COPYTO      = 5'd24,
`ifdef HRM_CU_SET_EN
        S_SET         = 5'd26,
`endif
        S_HALT        = 5'd25
    } state_t;

    localparam logic [3:0] OP_INBOX    = 4'h0;
    localparam logic [3:0] OP_OUTBOX   = 4'h1;
    localparam logic [3:0] OP_COPYFROM = 4'h2;
    localparam logic [3:0] OP_COPYTO   = 4'h3;
    localparam logic [3:0] OP_ADD      = 4'h4;
    localparam logic [3:0] OP_SUB      = 4'h5;
    localparam logic [3:0] OP_BUMPP    = 4'h6;
    localparam logic [3:0] OP_BUMPM    = 4'h7;
    localparam logic [3:0] OP_JUMP     = 4'h8;
    localparam logic [3:0] OP_JUMPZ    = 4'h9;
    localparam logic [3:0] OP_JUMPN    = 4'hA;
    localparam logic [3:0] OP_NOP_B    = 4'hB;
    localparam logic [3:0] OP_NOP_C    = 4'hC;
    localparam logic [3:0] OP_NOP_D    = 4'hD;
    localparam logic [3:0] OP_SET      = 4'hE;
    localparam logic [3:0] OP_HALT     = 4'hF;

    localparam logic [1:0] MUX_IN  = 2'b00;
    localparam logic [1:0] MUX_MEM = 2'b01;
    localparam logic [1:0] MUX_ALU = 2'b11;
`ifdef HRM_CU_SET_EN
    localparam logic [1:0] MUX_IMM = 2'b10;
`endif

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_INC = 3'b010;
    localparam logic [2:0] ALU_DEC = 3'b011;
    localparam logic [2:0] ALU_NEG = 3'b100;

    localparam logic [1:0] LAT_LAST = 2'(MEM_LAT - 1);

    state_t     state;
    state_t     state_nxt;
    logic [1:0] lat_cnt;
    logic       lat_done;
    logic       is_lat;
    logic [3:0] opcode;
    logic       indirect;
    logic       unused_instr_bits;

    assign opcode   = bus.INSTR[IW-1 -: 4];
    assign indirect = bus.INSTR[IW-5];
    // Operand bits below the indirect flag belong to the datapath only.
    assign unused_instr_bits = ^bus.INSTR;

    assign is_lat   = (state == S_FETCH_I) || (state == S_FETCH_O) ||
                      (state == S_READMEM) || (state == S_READMEM2);
    assign lat_done = (lat_cnt == LAT_LAST);

    // Counter restarts on every state change so each memory state sees a fresh MEM_LAT window.
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            state   <= S_RESET;
            lat_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state_nxt != state) begin
                lat_cnt <= '0;
            end else if (is_lat) begin
                lat_cnt <= lat_cnt + 2'd1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_RESET:       state_nxt = S_FETCH_I;
            S_FETCH_I:     if (lat_done) state_nxt = bus.debug ? S_WAIT_KEY : S_LOAD_IR;
            S_WAIT_KEY:    if (bus.nxtInstr) state_nxt = S_LOAD_IR;
            S_LOAD_IR:     state_nxt = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_INBOX:  state_nxt = bus.inEmpty ? S_WAIT_INBOX : S_INBOX;
                    OP_OUTBOX: state_nxt = bus.outFull ? S_WAIT_OUTBOX : S_OUTBOX;
                    OP_HALT:   state_nxt = S_HALT;
                    OP_NOP_B, OP_NOP_C, OP_NOP_D: state_nxt = S_INC_PC;
`ifndef HRM_CU_SET_EN
                    OP_SET:    state_nxt = S_INC_PC;
`endif
                    default:   state_nxt = S_INCPC2;
                endcase
            end
            S_WAIT_INBOX:  if (!bus.inEmpty) state_nxt = S_INBOX;
            S_WAIT_OUTBOX: if (!bus.outFull) state_nxt = S_OUTBOX;
            S_INBOX, S_OUTBOX, S_COPYFROM, S_ADD, S_SUB, S_COPYTO:
                           state_nxt = S_INC_PC;
            S_INC_PC, S_JUMP, S_JUMPZ, S_JUMPN:
                           state_nxt = S_FETCH_I;
            S_INCPC2:      state_nxt = S_FETCH_O;
            S_FETCH_O: begin
                if (lat_done) begin
                    case (opcode)
                        OP_JUMP:  state_nxt = S_JUMP;
                        OP_JUMPZ: state_nxt = S_JUMPZ;
                        OP_JUMPN: state_nxt = S_JUMPN;
`ifdef HRM_CU_SET_EN
                        OP_SET:   state_nxt = S_SET;
`endif
                        default:  state_nxt = S_LOAD_AR;
                    endcase
                end
            end
            S_LOAD_AR: begin
                if (indirect)                 state_nxt = S_READMEM2;
                else if (opcode == OP_COPYTO) state_nxt = S_COPYTO;
                else                          state_nxt = S_READMEM;
            end
            S_READMEM2:    if (lat_done) state_nxt = S_LOAD_AR2;
            S_LOAD_AR2:    state_nxt = (opcode == OP_COPYTO) ? S_COPYTO : S_READMEM;
            S_READMEM: begin
                if (lat_done) begin
                    case (opcode)
                        OP_COPYFROM: state_nxt = S_COPYFROM;
                        OP_ADD:      state_nxt = S_ADD;
                        OP_SUB:      state_nxt = S_SUB;
                        OP_BUMPP:    state_nxt = S_BUMPP;
                        OP_BUMPM:    state_nxt = S_BUMPM;
                        default:     state_nxt = S_HALT;
                    endcase
                end
            end
            S_BUMPP, S_BUMPM: state_nxt = S_COPYTO;
`ifdef HRM_CU_SET_EN
            S_SET:         state_nxt = S_INC_PC;
`endif
            S_HALT:        state_nxt = S_HALT;
            default:       state_nxt = S_RESET;
        endcase
    end

    always_comb begin
        bus.wIR    = 1'b0;
        bus.wR     = 1'b0;
        bus.srcA   = 1'b0;
        bus.wM     = 1'b0;
        bus.wAR    = 1'b0;
        bus.wPC    = 1'b0;
        bus.rIn    = 1'b0;
        bus.wO     = 1'b0;
        bus.ijump  = 1'b0;
        bus.branch = 1'b0;
        bus.rst    = 1'b0;
        bus.halt   = 1'b0;
        bus.muxR   = 2'b00;
        bus.aluCtl = 3'b000;
        case (state)
            S_RESET:    bus.rst = 1'b1;
            S_LOAD_IR:  bus.wIR = 1'b1;
            S_INBOX: begin
                bus.rIn  = 1'b1;
                bus.wR   = 1'b1;
                bus.muxR = MUX_IN;
            end
            S_OUTBOX:   bus.wO = 1'b1;
            S_INC_PC, S_INCPC2: bus.wPC = 1'b1;
            S_JUMP: begin
                bus.branch = 1'b1;
                bus.ijump  = 1'b1;
                bus.wPC    = 1'b1;
            end
            S_JUMPZ: begin
                bus.branch = 1'b1;
                bus.wPC    = 1'b1;
                bus.aluCtl = ALU_ADD;
            end
            S_JUMPN: begin
                bus.branch = 1'b1;
                bus.wPC    = 1'b1;
                bus.aluCtl = ALU_NEG;
            end
            S_LOAD_AR:  bus.wAR = 1'b1;
            S_LOAD_AR2: begin
                bus.srcA = 1'b1;
                bus.wAR  = 1'b1;
            end
            S_COPYFROM: begin
                bus.wR   = 1'b1;
                bus.muxR = MUX_MEM;
            end
            S_ADD, S_SUB, S_BUMPP, S_BUMPM: begin
                bus.wR   = 1'b1;
                bus.muxR = MUX_ALU;
                case (state)
                    S_SUB:   bus.aluCtl = ALU_SUB;
                    S_BUMPP: bus.aluCtl = ALU_INC;
                    S_BUMPM: bus.aluCtl = ALU_DEC;
                    default: bus.aluCtl = ALU_ADD;
                endcase
            end
            S_COPYTO:   bus.wM = 1'b1;
`ifdef HRM_CU_SET_EN
            S_SET: begin
                bus.wR   = 1'b1;
                bus.muxR = MUX_IMM;
            end
`endif
            S_HALT:     bus.halt = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_hrm_control_fsm.sv
// Directed bench for hrm_control_fsm: per-cycle vector table on a MEM_LAT=1 instance,
// hand sequences for single-step, async reset, halt hold and a MEM_LAT=2 instance.
module tb_hrm_control_fsm;

    typedef struct packed {
        logic       wIR, wR, srcA, wM, wAR, wPC, rIn, wO, ijump, branch, rst, halt;
        logic [1:0] muxR;
        logic [2:0] aluCtl;
    } outs_t;

    typedef struct {
        logic       do_rst;
        logic [7:0] instr;
        logic       ie;
        logic       of;
        outs_t      exp;
    } vec_t;

    localparam outs_t E_NONE  = '0;
    localparam outs_t E_RST   = '{rst: 1'b1, default: '0};
    localparam outs_t E_WIR   = '{wIR: 1'b1, default: '0};
    localparam outs_t E_WPC   = '{wPC: 1'b1, default: '0};
    localparam outs_t E_WO    = '{wO: 1'b1, default: '0};
    localparam outs_t E_WAR   = '{wAR: 1'b1, default: '0};
    localparam outs_t E_WM    = '{wM: 1'b1, default: '0};
    localparam outs_t E_HALT  = '{halt: 1'b1, default: '0};
    localparam outs_t E_ARS   = '{srcA: 1'b1, wAR: 1'b1, default: '0};
    localparam outs_t E_INBOX = '{rIn: 1'b1, wR: 1'b1, muxR: 2'b00, default: '0};
    localparam outs_t E_CPF   = '{wR: 1'b1, muxR: 2'b01, default: '0};
    localparam outs_t E_ADD   = '{wR: 1'b1, muxR: 2'b11, aluCtl: 3'b000, default: '0};
    localparam outs_t E_SUB   = '{wR: 1'b1, muxR: 2'b11, aluCtl: 3'b001, default: '0};
    localparam outs_t E_BUMPP = '{wR: 1'b1, muxR: 2'b11, aluCtl: 3'b010, default: '0};
    localparam outs_t E_BUMPM = '{wR: 1'b1, muxR: 2'b11, aluCtl: 3'b011, default: '0};
    localparam outs_t E_JUMP  = '{branch: 1'b1, ijump: 1'b1, wPC: 1'b1, default: '0};
    localparam outs_t E_JUMPZ = '{branch: 1'b1, wPC: 1'b1, aluCtl: 3'b000, default: '0};
    localparam outs_t E_JUMPN = '{branch: 1'b1, wPC: 1'b1, aluCtl: 3'b100, default: '0};
`ifdef HRM_CU_SET_EN
    localparam outs_t E_SET   = '{wR: 1'b1, muxR: 2'b10, default: '0};
`endif

    logic clk;
    logic i_rst;
    int   n_chk;
    int   n_fail;
    vec_t vecs[$];

    hrm_control_fsm_if #(.IW(8)) if1();
    hrm_control_fsm_if #(.IW(8)) if2();

    hrm_control_fsm #(.IW(8), .MEM_LAT(1)) dut1 (.clk(clk), .i_rst(i_rst), .bus(if1));
    hrm_control_fsm #(.IW(8), .MEM_LAT(2)) dut2 (.clk(clk), .i_rst(i_rst), .bus(if2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, limit 100000", $time);
        $fatal(1, "watchdog");
    end

    function automatic outs_t get1();
        outs_t o;
        o = '{if1.wIR, if1.wR, if1.srcA, if1.wM, if1.wAR, if1.wPC, if1.rIn, if1.wO,
              if1.ijump, if1.branch, if1.rst, if1.halt, if1.muxR, if1.aluCtl};
        return o;
    endfunction

    function automatic outs_t get2();
        outs_t o;
        o = '{if2.wIR, if2.wR, if2.srcA, if2.wM, if2.wAR, if2.wPC, if2.rIn, if2.wO,
              if2.ijump, if2.branch, if2.rst, if2.halt, if2.muxR, if2.aluCtl};
        return o;
    endfunction

    task automatic chk(input string nm, input outs_t got, input outs_t exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got outputs %h, expected %h", nm, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        i_rst = 1'b1;
        #2;
        i_rst = 1'b0;
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic v(input logic rs, input logic [7:0] ins, input logic ie, input logic of,
                     input outs_t e);
        vec_t r;
        r.do_rst = rs;
        r.instr  = ins;
        r.ie     = ie;
        r.of     = of;
        r.exp    = e;
        vecs.push_back(r);
    endtask

    // Reset, FETCH_I, LOAD_IR, DECODE with idle flags.
    task automatic pre(input logic [7:0] ins);
        v(1, ins, 0, 0, E_RST);
        v(0, ins, 0, 0, E_NONE);
        v(0, ins, 0, 0, E_WIR);
        v(0, ins, 0, 0, E_NONE);
    endtask

    task automatic o(input logic [7:0] ins, input outs_t e);
        v(0, ins, 0, 0, e);
    endtask

    initial begin
        outs_t exp2[16];
        n_chk  = 0;
        n_fail = 0;
        i_rst  = 1'b1;
        if1.INSTR = 8'h00; if1.inEmpty = 1'b0; if1.outFull = 1'b0;
        if1.debug = 1'b0;  if1.nxtInstr = 1'b0;
        if2.INSTR = 8'h40; if2.inEmpty = 1'b0; if2.outFull = 1'b0;
        if2.debug = 1'b0;  if2.nxtInstr = 1'b0;

        // INBOX without wait, then with inEmpty stall
        pre(8'h00); o(8'h00, E_INBOX); o(8'h00, E_WPC); o(8'h00, E_NONE);
        pre(8'h00);
        v(0, 8'h00, 1, 0, E_NONE); v(0, 8'h00, 1, 0, E_NONE);
        o(8'h00, E_INBOX); o(8'h00, E_WPC);
        // OUTBOX held off by outFull for 5 cycles
        pre(8'h10);
        for (int k = 0; k < 5; k++) v(0, 8'h10, 0, 1, E_NONE);
        o(8'h10, E_WO); o(8'h10, E_WPC);
        // jumps
        pre(8'h80); o(8'h80, E_WPC); o(8'h80, E_NONE); o(8'h80, E_JUMP); o(8'h80, E_NONE); o(8'h80, E_WIR);
        pre(8'h90); o(8'h90, E_WPC); o(8'h90, E_NONE); o(8'h90, E_JUMPZ); o(8'h90, E_NONE);
        pre(8'hA0); o(8'hA0, E_WPC); o(8'hA0, E_NONE); o(8'hA0, E_JUMPN); o(8'hA0, E_NONE);
        // NOPs
        pre(8'hB0); o(8'hB0, E_WPC); o(8'hB0, E_NONE); o(8'hB0, E_WIR);
        pre(8'hD0); o(8'hD0, E_WPC); o(8'hD0, E_NONE);
        // memory ops
        pre(8'h20); o(8'h20, E_WPC); o(8'h20, E_NONE); o(8'h20, E_WAR); o(8'h20, E_NONE); o(8'h20, E_CPF); o(8'h20, E_WPC);
        pre(8'h30); o(8'h30, E_WPC); o(8'h30, E_NONE); o(8'h30, E_WAR); o(8'h30, E_WM); o(8'h30, E_WPC);
        pre(8'h38); o(8'h38, E_WPC); o(8'h38, E_NONE); o(8'h38, E_WAR); o(8'h38, E_NONE); o(8'h38, E_ARS); o(8'h38, E_WM); o(8'h38, E_WPC);
        pre(8'h50); o(8'h50, E_WPC); o(8'h50, E_NONE); o(8'h50, E_WAR); o(8'h50, E_NONE); o(8'h50, E_SUB); o(8'h50, E_WPC);
        pre(8'h68); o(8'h68, E_WPC); o(8'h68, E_NONE); o(8'h68, E_WAR); o(8'h68, E_NONE); o(8'h68, E_ARS);
        o(8'h68, E_NONE); o(8'h68, E_BUMPP); o(8'h68, E_WM); o(8'h68, E_WPC);
        pre(8'h70); o(8'h70, E_WPC); o(8'h70, E_NONE); o(8'h70, E_WAR); o(8'h70, E_NONE); o(8'h70, E_BUMPM); o(8'h70, E_WM); o(8'h70, E_WPC);
        // opcode changed to INBOX while in READMEM: not a memory op, so HALT
        pre(8'h20); o(8'h20, E_WPC); o(8'h20, E_NONE); o(8'h20, E_WAR); o(8'h20, E_NONE); o(8'h00, E_HALT);
`ifdef HRM_CU_SET_EN
        pre(8'hE0); o(8'hE0, E_WPC); o(8'hE0, E_NONE); o(8'hE0, E_SET); o(8'hE0, E_WPC); o(8'hE0, E_NONE);
`else
        pre(8'hE0); o(8'hE0, E_WPC); o(8'hE0, E_NONE); o(8'hE0, E_WIR); o(8'hE0, E_NONE);
`endif
        pre(8'hF0); o(8'hF0, E_HALT);

        foreach (vecs[i]) begin
            if1.INSTR   = vecs[i].instr;
            if1.inEmpty = vecs[i].ie;
            if1.outFull = vecs[i].of;
            if (vecs[i].do_rst) do_reset();
            else step();
            chk($sformatf("vec%0d instr %h", i, vecs[i].instr), get1(), vecs[i].exp);
        end

        // HALT holds for 20 cycles whatever the instruction
        if1.INSTR = 8'h00;
        for (int k = 0; k < 20; k++) begin
            step();
            chk($sformatf("halt_hold%0d", k), get1(), E_HALT);
        end

        // single-step: FETCH_I -> WAIT_KEY, LOAD_IR only after the pulse
        if1.INSTR = 8'h00;
        if1.debug = 1'b1;
        do_reset();
        chk("dbg_reset", get1(), E_RST);
        step(); chk("dbg_fetch", get1(), E_NONE);
        for (int k = 0; k < 10; k++) begin
            step();
            chk($sformatf("dbg_wait%0d", k), get1(), E_NONE);
        end
        if1.nxtInstr = 1'b1;
        step();
        if1.nxtInstr = 1'b0;
        chk("dbg_load_ir", get1(), E_WIR);
        step(); chk("dbg_decode", get1(), E_NONE);

        // asynchronous reset in the middle of WAIT_KEY
        do_reset();
        step(); step();
        chk("dbg_wait_again", get1(), E_NONE);
        #3;
        i_rst = 1'b1;
        #1;
        chk("async_rst_midwait", get1(), E_RST);
        #2;
        i_rst = 1'b0;
        if1.debug = 1'b0;
        step(); chk("after_async_fetch", get1(), E_NONE);
        step(); chk("after_async_load_ir", get1(), E_WIR);

        // MEM_LAT=2 direct ADD
        exp2 = '{E_RST, E_NONE, E_NONE, E_WIR, E_NONE, E_WPC, E_NONE, E_NONE,
                 E_WAR, E_NONE, E_NONE, E_ADD, E_WPC, E_NONE, E_NONE, E_WIR};
        do_reset();
        chk("lat2_c0", get2(), exp2[0]);
        for (int k = 1; k < 16; k++) begin
            step();
            chk($sformatf("lat2_c%0d", k), get2(), exp2[k]);
        end
        // asynchronous reset during FETCH_O, then a full-length FETCH_I
        step(); step(); step();
        chk("lat2_fetch_o", get2(), E_NONE);
        #3;
        i_rst = 1'b1;
        #1;
        chk("lat2_async_rst", get2(), E_RST);
        #2;
        i_rst = 1'b0;
        step(); chk("lat2_refetch0", get2(), E_NONE);
        step(); chk("lat2_refetch1", get2(), E_NONE);
        step(); chk("lat2_reload_ir", get2(), E_WIR);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/hrm_control_fsm.md
HRM_CONTROL_FSM -- requirements
Module: hrm_control_fsm

Interface
REQ-001 Parameter IW, default 8, instruction width; legal range 5..16.
REQ-002 Parameter MEM_LAT, default 1, memory read latency in cycles; legal range 1..4.
REQ-003 clk  in  1  single system clock; all state changes on its rising edge.
REQ-004 i_rst  in  1  reset; asynchronous and active-high.
REQ-005 INSTR  in  IW  current instruction; opcode = INSTR[IW-1:IW-4], indirect = INSTR[IW-5].
REQ-006 inEmpty / outFull  in  1 each  inbox empty / outbox full flags.
REQ-007 debug / nxtInstr  in  1 each  single-step enable / step pulse.
REQ-008 wIR, wR, srcA, wM, wAR, wPC, rIn, wO, ijump, branch, rst, halt  out  1 each  datapath strobes.
REQ-009 muxR  out  2  register source select: 00 inbox, 01 memory, 10 immediate, 11 ALU.
REQ-010 aluCtl  out  3  ALU op: 000 add/zero test, 001 sub, 010 inc, 011 dec, 100 negative test.

Function
REQ-011 Outputs SHALL be Moore (state-only); every output is 0 in any state not listed for it.
REQ-012 Opcodes SHALL be: 0 INBOX, 1 OUTBOX, 2 COPYFROM, 3 COPYTO, 4 ADD, 5 SUB, 6 BUMP+, 7 BUMP-, 8 JUMP, 9 JUMPZ, A JUMPN, B-D NOP, E SET, F HALT.
REQ-013 Flow SHALL be RESET -> FETCH_I -> LOAD_IR(wIR) -> DECODE.
REQ-014 FETCH_I, FETCH_O, READMEM and READMEM2 SHALL each last exactly MEM_LAT cycles, timed by an internal counter cleared on entry; all other states last 1 cycle unless they are wait states.
REQ-015 In FETCH_I with debug=1 the FSM SHALL go to WAIT_KEY, then to LOAD_IR in the cycle after nxtInstr=1 is sampled.
REQ-016 DECODE transitions:
  - INBOX -> WAIT_INBOX if inEmpty, else INBOX.
  - OUTBOX -> WAIT_OUTBOX if outFull, else OUTBOX.
  - HALT -> HALT.
  - NOP -> Inc_PC.
  - all others -> INCPC2(wPC) -> FETCH_O.
REQ-017 WAIT_INBOX / WAIT_OUTBOX SHALL hold until inEmpty=0 / outFull=0 is sampled.
REQ-018 INBOX SHALL drive rIn=1, wR=1, muxR=00; OUTBOX SHALL drive wO=1; both then go to Inc_PC(wPC) -> FETCH_I.
REQ-019 FETCH_O SHALL exit as follows:
  - JUMP -> JUMP (branch, ijump, wPC).
  - JUMPZ -> JUMPZ (branch, wPC, aluCtl=000).
  - JUMPN -> JUMPN (branch, wPC, aluCtl=100).
  - SET -> SET.
  - others -> LOAD_AR(wAR).
  - JUMP, JUMPZ and JUMPN all return to FETCH_I.
REQ-020 LOAD_AR SHALL exit as follows:
  - direct COPYTO -> COPYTO(wM).
  - indirect -> READMEM2 -> LOAD_AR2(srcA, wAR); LOAD_AR2 then goes to COPYTO for COPYTO, else READMEM.
  - otherwise -> READMEM.
REQ-021 READMEM SHALL exit as follows:
  - COPYFROM (muxR=01, wR) -> Inc_PC.
  - ADD (muxR=11, wR, aluCtl=000) -> Inc_PC.
  - SUB (muxR=11, wR, aluCtl=001) -> Inc_PC.
  - BUMP+ (aluCtl=010) / BUMP- (aluCtl=011), each with muxR=11, wR -> COPYTO.
  - any other opcode -> HALT.
REQ-022 COPYTO SHALL go to Inc_PC.
REQ-023 HALT SHALL assert halt=1 continuously and leave only via i_rst.
REQ-024 RESET SHALL assert rst=1 for one cycle, then go to FETCH_I.
REQ-025 Unused state encodings SHALL go to RESET on the next clock.

Reset
REQ-026 i_rst=1 SHALL force state RESET and clear the latency counter immediately, regardless of clock or current state, including mid-wait and mid-latency.
REQ-027 During reset all outputs SHALL be 0 except rst=1.
REQ-028 The power-up/initial state SHALL be RESET.

Configuration
REQ-029 Macro HRM_CU_SET_EN:
  - Defined: opcode E follows the SET path; state SET drives muxR=10, wR=1 and goes to Inc_PC.
  - Undefined: opcode E is decoded as NOP (DECODE -> Inc_PC), muxR never takes the value 10, and the SET state is absent.

Verification
REQ-030 MEM_LAT=1, INSTR=0x00, inEmpty=0, release i_rst -> wIR at cycle 2, rIn=wR=1 with muxR=00 at cycle 4, wPC at cycle 5.
REQ-031 MEM_LAT=2, INSTR=0x40 -> INCPC2, 2 cycles FETCH_O, LOAD_AR, 2 cycles READMEM, then ADD (muxR=11, wR=1, aluCtl=000), then wPC.
REQ-032 INSTR=0x10, outFull=1 for 5 cycles -> no wO while outFull=1; wO=1 exactly one cycle after outFull falls.
REQ-033 INSTR=0x68 (indirect BUMP+) -> sequence LOAD_AR, READMEM2, LOAD_AR2 (srcA=wAR=1), READMEM, BUMPP (aluCtl=010), COPYTO (wM=1), Inc_PC.
REQ-034 debug=1, nxtInstr low for 10 cycles then pulsed -> wIR only in the cycle after the pulse is sampled; i_rst asserted mid-wait -> rst=1 asynchronously, all other outputs 0.
REQ-035 INSTR=0xE0 -> with HRM_CU_SET_EN: muxR=10, wR=1 after FETCH_O; without it: wPC directly after DECODE and wR never asserted. INSTR=0xF0 -> halt held for 20 cycles.
